dpram_sync: RTL and testbench

Synchronous-read, parametrised dual-port RAM for the core's unified instruction/data memory. It replaces the combinational-read word-only RAM. The data port adds byte/halfword/word access, sign/zero extension and misalignment detection, behind a one-cycle req/ack handshake. The instruction port is a read-only fetch port with the same latency, with write-first forwarding when it collides with a data-port store.

---
 rtl/dpram_sync.sv | 183 ++++++++++++++++++
 tb/tb_dpram_sync.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dpram_sync.sv
`default_nettype none
// ============================================================================
// Module   : dpram_sync
// Purpose  : Synchronous-read dual-port RAM for the unified instruction/data
//            memory. The data port does byte/half/word loads and stores with
//            sign/zero extension and misalignment detection. The instruction
//            port is a read-only word fetch port. Storage is big-endian.
// Ports    : clk_i, rst_i        - clock, asynchronous active-high reset
//            req_i, we_i         - data request, 1 = store / 0 = load
//            size_i, unsigned_i  - 00 byte, 01 half, 10 word; zero-extend
//            addr_i, data_i      - byte address, right-aligned store data
//            ack_o, data_o, err_o- response one cycle after the request
//            inst_req_i, pc_i    - fetch request and word address
//            inst_ack_o, inst_o  - fetch response one cycle after request
// Revision : 1.0 - initial release
// ============================================================================
module dpram_sync #(
  parameter int RAM_SIZE       = 4096,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  err_o,
  input  logic                  inst_req_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  inst_ack_o,
  output logic [DATA_WIDTH-1:0] inst_o
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int         WORD_AW = RAM_ADDR_WIDTH - 2;

  logic [7:0] mem [RAM_SIZE];

  logic [RAM_ADDR_WIDTH-1:0] a;
  logic [WORD_AW-1:0]        d_word;
  logic [WORD_AW-1:0]        f_word;
  logic                      misaligned;
  logic                      store_en;
  logic [3:0]                be;        // bit k = byte lane k (lane 0 is the MSB)
  logic [31:0]               wlanes;    // store data replicated onto every lane
  logic [31:0]               rword;
  logic [31:0]               iword;
  logic [7:0]                lb;
  logic [15:0]               lh;
  logic [31:0]               load_val;
  logic                      unused_addr_bits;

  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      inst_ack_q, inst_ack_d;
  logic [DATA_WIDTH-1:0]     inst_q, inst_d;

  assign a        = addr_i[RAM_ADDR_WIDTH-1:0];
  assign d_word   = a[RAM_ADDR_WIDTH-1:2];
  assign f_word   = pc_i[RAM_ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                              pc_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH], pc_i[1:0]};

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b0000;
    wlanes     = data_i;
    case (size_i)
      SZ_BYTE: begin
        be[a[1:0]] = 1'b1;
        wlanes     = {4{data_i[7:0]}};
      end
      SZ_HALF: begin
        misaligned = a[0];
        be         = a[1] ? 4'b1100 : 4'b0011;
        wlanes     = {2{data_i[15:0]}};
      end
      SZ_WORD: begin
        misaligned = (a[1:0] != 2'b00);
        be         = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign store_en = req_i & we_i & ~misaligned & ~rst_i;

  // Word reads of the data and fetch addresses. The fetch word merges the
  // bytes being stored on the same edge so the fetch sees post-store data.
  always_comb begin
    rword = '0;
    iword = '0;
    for (int k = 0; k < 4; k++) begin
      rword[31-8*k -: 8] = mem[{d_word, 2'(k)}];
      if (store_en && be[k] && (f_word == d_word))
        iword[31-8*k -: 8] = wlanes[31-8*k -: 8];
      else
        iword[31-8*k -: 8] = mem[{f_word, 2'(k)}];
    end
  end

  always_comb begin
    lb = rword[31:24];
    case (a[1:0])
      2'd0: lb = rword[31:24];
      2'd1: lb = rword[23:16];
      2'd2: lb = rword[15:8];
      default: lb = rword[7:0];
    endcase
    lh = a[1] ? rword[15:0] : rword[31:16];
    case (size_i)
      SZ_BYTE: load_val = unsigned_i ? {24'b0, lb} : {{24{lb[7]}}, lb};
      SZ_HALF: load_val = unsigned_i ? {16'b0, lh} : {{16{lh[15]}}, lh};
      default: load_val = rword;
    endcase
  end

  // Memory has no reset and is also written by the writeByte debug task.
  always @(posedge clk_i) begin
    if (store_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[{d_word, 2'(k)}] <= wlanes[31-8*k -: 8];
      end
    end
  end

  always_comb begin
    ack_d      = req_i;
    err_d      = err_q;
    data_d     = data_q;
    inst_ack_d = inst_req_i;
    inst_d     = inst_q;
    if (req_i) begin
      err_d  = misaligned;
      data_d = (misaligned || we_i) ? '0 : load_val;
    end
    if (inst_req_i) inst_d = iword;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      inst_ack_q <= 1'b0;
      inst_q     <= '0;
    end else begin
      ack_q      <= ack_d;
      err_q      <= err_d;
      data_q     <= data_d;
      inst_ack_q <= inst_ack_d;
      inst_q     <= inst_d;
    end
  end

  assign ack_o      = ack_q;
  assign err_o      = err_q;
  assign data_o     = data_q;
  assign inst_ack_o = inst_ack_q;
  assign inst_o     = inst_q;

  // Debug access to the byte array, bypassing the ports.
  task automatic readByte(input logic [RAM_ADDR_WIDTH-1:0] byte_addr,
                          output logic [7:0] val);
    val = mem[byte_addr];
  endtask

  task automatic writeByte(input logic [RAM_ADDR_WIDTH-1:0] byte_addr,
                           input logic [7:0] val);
    mem[byte_addr] <= val;
  endtask

endmodule
`default_nettype wire

// File: tb/tb_dpram_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_sync
// Purpose  : Directed, table-driven checks of dpram_sync data and fetch ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_sync;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic        ack_o;
  logic [31:0] data_o;
  logic        err_o;
  logic        inst_req_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        inst_ack_o;
  logic [31:0] inst_o;

  int checks = 0;
  int errors = 0;

  dpram_sync #(
    .RAM_SIZE(4096), .RAM_ADDR_WIDTH(12), .DATA_WIDTH(32), .ADDR_WIDTH(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i),
    .data_i(data_i), .ack_o(ack_o), .data_o(data_o), .err_o(err_o),
    .inst_req_i(inst_req_i), .pc_i(pc_i), .inst_ack_o(inst_ack_o),
    .inst_o(inst_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NV = 23;
  vec_t v[NV];

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] ad, input logic [31:0] wd);
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns;
    addr_i = ad; data_i = wd;
  endtask

  initial begin : main
    logic [7:0] b;

    //        we    size   uns   addr        wdata         exp_data      err
    v[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,     32'h11223344, 32'h0,        1'b0};
    v[1]  = '{1'b0, 2'b00, 1'b1, 32'h10,     32'h0,        32'h11,       1'b0};
    v[2]  = '{1'b0, 2'b00, 1'b1, 32'h11,     32'h0,        32'h22,       1'b0};
    v[3]  = '{1'b0, 2'b00, 1'b1, 32'h12,     32'h0,        32'h33,       1'b0};
    v[4]  = '{1'b0, 2'b00, 1'b0, 32'h13,     32'h0,        32'h44,       1'b0};
    v[5]  = '{1'b1, 2'b10, 1'b0, 32'h20,     32'h01020304, 32'h0,        1'b0};
    v[6]  = '{1'b1, 2'b00, 1'b0, 32'h21,     32'hAAAAAA80, 32'h0,        1'b0};
    v[7]  = '{1'b0, 2'b00, 1'b0, 32'h21,     32'h0,        32'hFFFFFF80, 1'b0};
    v[8]  = '{1'b0, 2'b00, 1'b1, 32'h21,     32'h0,        32'h00000080, 1'b0};
    v[9]  = '{1'b0, 2'b10, 1'b0, 32'h20,     32'h0,        32'h01800304, 1'b0};
    v[10] = '{1'b1, 2'b01, 1'b0, 32'h13,     32'h0000BEEF, 32'h0,        1'b1};
    v[11] = '{1'b0, 2'b10, 1'b0, 32'h10,     32'h0,        32'h11223344, 1'b0};
    v[12] = '{1'b0, 2'b10, 1'b0, 32'h12,     32'h0,        32'h0,        1'b1};
    v[13] = '{1'b0, 2'b11, 1'b0, 32'h0,      32'h0,        32'h0,        1'b1};
    v[14] = '{1'b1, 2'b01, 1'b0, 32'h22,     32'h12348001, 32'h0,        1'b0};
    v[15] = '{1'b0, 2'b01, 1'b0, 32'h22,     32'h0,        32'hFFFF8001, 1'b0};
    v[16] = '{1'b0, 2'b01, 1'b1, 32'h22,     32'h0,        32'h00008001, 1'b0};
    v[17] = '{1'b0, 2'b01, 1'b0, 32'h20,     32'h0,        32'h00000180, 1'b0};
    v[18] = '{1'b0, 2'b10, 1'b0, 32'h20,     32'h0,        32'h01808001, 1'b0};
    v[19] = '{1'b0, 2'b10, 1'b0, 32'h1010,   32'h0,        32'h11223344, 1'b0};
    v[20] = '{1'b1, 2'b00, 1'b0, 32'h2FFF,   32'h00000077, 32'h0,        1'b0};
    v[21] = '{1'b0, 2'b00, 1'b1, 32'hFFF,    32'h0,        32'h77,       1'b0};
    v[22] = '{1'b0, 2'b01, 1'b1, 32'h10,     32'h0,        32'h1122,     1'b0};

    // Reset state
    #1 rst_i = 1'b1;
    #2;
    chk("reset ack_o", {31'b0, ack_o}, 32'h0);
    chk("reset err_o", {31'b0, err_o}, 32'h0);
    chk("reset data_o", data_o, 32'h0);
    chk("reset inst_ack_o", {31'b0, inst_ack_o}, 32'h0);
    chk("reset inst_o", inst_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Back-to-back table: every vector issued on consecutive edges
    for (int i = 0; i < NV; i++) begin
      drive(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata);
      @(posedge clk_i); #1;
      chk($sformatf("vec%0d ack", i), {31'b0, ack_o}, 32'h1);
      chk($sformatf("vec%0d data", i), data_o, v[i].exp_data);
      chk($sformatf("vec%0d err", i), {31'b0, err_o}, {31'b0, v[i].exp_err});
      chk($sformatf("vec%0d inst_ack", i), {31'b0, inst_ack_o}, 32'h0);
    end
    req_i = 1'b0;
    @(posedge clk_i); #1;
    chk("idle ack", {31'b0, ack_o}, 32'h0);
    chk("idle data hold", data_o, 32'h1122);

    // Same-edge store and fetch of the same word: full and partial merge
    drive(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    inst_req_i = 1'b1; pc_i = 32'h42;
    @(posedge clk_i); #1;
    chk("coll ack", {31'b0, ack_o}, 32'h1);
    chk("coll inst_ack", {31'b0, inst_ack_o}, 32'h1);
    chk("coll inst word", inst_o, 32'hDEADBEEF);
    drive(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000005A);
    pc_i = 32'h40;
    @(posedge clk_i); #1;
    chk("coll byte merge", inst_o, 32'hDE5ABEEF);
    req_i = 1'b0; pc_i = 32'h13;
    @(posedge clk_i); #1;
    chk("fetch unaligned pc", inst_o, 32'h11223344);
    chk("fetch no data ack", {31'b0, ack_o}, 32'h0);
    inst_req_i = 1'b0;
    @(posedge clk_i); #1;
    chk("fetch ack drops", {31'b0, inst_ack_o}, 32'h0);
    chk("fetch inst hold", inst_o, 32'h11223344);

    // Debug write, then read back through the data port
    dut.writeByte(12'h050, 8'hC3);
    #1;
    drive(1'b0, 2'b00, 1'b1, 32'h50, 32'h0);
    @(posedge clk_i); #1;
    chk("writeByte load", data_o, 32'h000000C3);

    // Reset asserted between a request edge and its ack
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    inst_req_i = 1'b1; pc_i = 32'h20;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    chk("midrst ack", {31'b0, ack_o}, 32'h0);
    chk("midrst data", data_o, 32'h0);
    chk("midrst inst_ack", {31'b0, inst_ack_o}, 32'h0);
    chk("midrst inst", inst_o, 32'h0);
    inst_req_i = 1'b0;
    drive(1'b1, 2'b00, 1'b0, 32'h10, 32'h000000FF);
    @(posedge clk_i); #1;
    chk("rst held ack", {31'b0, ack_o}, 32'h0);
    req_i = 1'b0;
    dut.readByte(12'h010, b);
    chk("mem kept 0x10", {24'b0, b}, 32'h11);
    dut.readByte(12'h021, b);
    chk("mem kept 0x21", {24'b0, b}, 32'h80);
    dut.readByte(12'h041, b);
    chk("mem kept 0x41", {24'b0, b}, 32'h5A);
    rst_i = 1'b0;
    drive(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    @(posedge clk_i); #1;
    chk("post-rst ack", {31'b0, ack_o}, 32'h1);
    chk("post-rst data", data_o, 32'h11);
    req_i = 1'b0;
    @(posedge clk_i); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
